// File: rtl/bidsn_pkg.sv
// Shared types and constants for the sealed-bid auction controller.
// Grant arbitration mode is selected with the BIDSN_RR_ARB_EN macro (see bidsn_arb).
package bidsn_pkg;

    typedef enum logic [3:0] {
        NoOperation_op = 4'd0,
        Unlock_op      = 4'd1,
        Lock_op        = 4'd2,
        Load_op        = 4'd3,
        SetMask_op     = 4'd6,
        SetTimer_op    = 4'd7,
        BidCharge_op   = 4'd8,
        RoundActive_op = 4'd9,
        RoundOver_op   = 4'd10
    } operation_t;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED   = 2'd1,
        ACTIVE   = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        NONE   = 3'd0,
        BADOP  = 3'd1,
        BADKEY = 3'd2
    } ctrl_err_t;

    localparam logic [1:0] BID_OK     = 2'b00;
    localparam logic [1:0] BID_MASKED = 2'b01;
    localparam logic [1:0] BID_LOW    = 2'b10;
    localparam logic [1:0] BID_FUNDS  = 2'b11;

    // Reserved opcodes fall through every list and are therefore illegal everywhere.
    function automatic logic op_legal(input state_t s, input logic [3:0] op);
        case (s)
            UNLOCKED: return op inside {NoOperation_op, Load_op, SetMask_op,
                                        SetTimer_op, BidCharge_op, Lock_op};
            LOCKED:   return op inside {NoOperation_op, Unlock_op, RoundActive_op};
            ACTIVE:   return op inside {NoOperation_op, RoundOver_op};
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/bidsn_arb.sv
// Bid grant selection: fixed priority (lowest index first) by default,
// round-robin starting after the last granted index when BIDSN_RR_ARB_EN is defined.
module bidsn_arb
    import bidsn_pkg::*;
#(
    parameter int NUM_BIDDERS = 3
) (
`ifdef BIDSN_RR_ARB_EN
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           advance,
`endif
    input  logic [NUM_BIDDERS-1:0]         req,
    output logic                           gnt_valid,
    output logic [$clog2(NUM_BIDDERS)-1:0] gnt_idx
);

    localparam int IDX_W = $clog2(NUM_BIDDERS);

`ifdef BIDSN_RR_ARB_EN
    logic [IDX_W-1:0] last_q;

    // Starting at N-1 makes the first search after reset begin at bidder 0.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_q <= IDX_W'(NUM_BIDDERS - 1);
        end else if (advance && gnt_valid) begin
            last_q <= gnt_idx;
        end
    end

    always_comb begin
        int j;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        j         = 0;
        // Walk offsets from farthest to nearest so the nearest requester wins.
        for (int k = NUM_BIDDERS; k >= 1; k--) begin
            j = int'(last_q) + k;
            if (j >= NUM_BIDDERS) j = j - NUM_BIDDERS;
            if (req[j]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IDX_W'(j);
            end
        end
    end
`else
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int i = NUM_BIDDERS - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IDX_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/bidsn_ctrl.sv
// Auction controller: opcode-driven setup/lock, timed bidding rounds, per-bidder balances.
// Arbitration mode follows BIDSN_RR_ARB_EN (round-robin when defined, fixed priority otherwise).
module bidsn_ctrl
    import bidsn_pkg::*;
#(
    parameter int NUM_BIDDERS = 3,
    parameter int BID_W       = 16,
    parameter int BAL_W       = 32,
    parameter int TIMER_W     = 16
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic [3:0]                             C_op,
    input  logic                                   C_start,
    input  logic [$clog2(NUM_BIDDERS)-1:0]         C_idx,
    input  logic [31:0]                            C_data,
    input  logic [NUM_BIDDERS-1:0]                 bid,
    input  logic [NUM_BIDDERS-1:0]                 retract,
    input  logic [NUM_BIDDERS-1:0][BID_W-1:0]      bidAmt,
    output logic [NUM_BIDDERS-1:0]                 ack,
    output logic [NUM_BIDDERS-1:0]                 win,
    output logic [NUM_BIDDERS-1:0][1:0]            bidErr,
    output logic [NUM_BIDDERS-1:0][BAL_W-1:0]      balance,
    output logic                                   ready,
    output logic [2:0]                             err,
    output logic                                   roundOver,
    output logic [BID_W-1:0]                       maxBid,
    output state_t                                 dbg_state
);

    localparam int IDX_W = $clog2(NUM_BIDDERS);

    // Control handshake: an op is taken when C_start && ready; ready then drops for
    // exactly one cycle, during which C_start is ignored, and err reflects the op.
    state_t                            state_q, state_d;
    logic                              ready_q;
    ctrl_err_t                         err_q, err_d;
    logic [31:0]                       key_q;
    logic [NUM_BIDDERS-1:0]            mask_q;
    logic [TIMER_W-1:0]                reload_q, timer_q;
    logic [BID_W-1:0]                  charge_q, max_q;
    logic                              leader_valid_q;
    logic [IDX_W-1:0]                  leader_q;
    logic [NUM_BIDDERS-1:0][BAL_W-1:0] bal_q;
    logic [NUM_BIDDERS-1:0]            ack_q, win_q;
    logic [NUM_BIDDERS-1:0][1:0]       bid_err_q;
    logic                              round_over_q;

    logic                   accept, legal, key_ok, round_end;
    logic                   do_load, do_mask, do_timer, do_charge, do_lock, do_unlock_ok, do_start;
    logic                   gnt_valid, take_ok, bid_win, retract_hit;
    logic [IDX_W-1:0]       gnt_idx;
    logic [NUM_BIDDERS-1:0] gnt_oh;
    logic [BID_W-1:0]       amt;
    logic [BAL_W:0]         amt_ext, chg_ext, bal_ext;
    logic [1:0]             bid_code;

    assign accept    = C_start && ready_q;
    assign legal     = op_legal(state_q, C_op);
    assign key_ok    = (C_data == key_q);
    assign round_end = (state_q == ACTIVE) &&
                       ((timer_q <= TIMER_W'(1)) || (accept && C_op == RoundOver_op));

    // A requester whose ack is on the wire this cycle is still holding bid; skip it.
    bidsn_arb #(.NUM_BIDDERS(NUM_BIDDERS)) u_arb (
`ifdef BIDSN_RR_ARB_EN
        .clk       (clk),
        .reset_n   (reset_n),
        .advance   (take_ok),
`endif
        .req       (bid & ~ack_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= UNLOCKED;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (accept && legal) begin
            case (state_q)
                UNLOCKED: if (C_op == Lock_op) state_d = LOCKED;
                LOCKED: begin
                    if (C_op == Unlock_op && key_ok)   state_d = UNLOCKED;
                    else if (C_op == RoundActive_op)   state_d = ACTIVE;
                end
                default: ;
            endcase
        end
        if (round_end) state_d = LOCKED;
    end

    always_comb begin
        do_load      = accept && legal && (C_op == Load_op);
        do_mask      = accept && legal && (C_op == SetMask_op);
        do_timer     = accept && legal && (C_op == SetTimer_op);
        do_charge    = accept && legal && (C_op == BidCharge_op);
        do_lock      = accept && legal && (C_op == Lock_op);
        do_unlock_ok = accept && legal && (C_op == Unlock_op) && key_ok;
        do_start     = accept && legal && (C_op == RoundActive_op);

        if (!legal)                            err_d = BADOP;
        else if (C_op == Unlock_op && !key_ok) err_d = BADKEY;
        else                                   err_d = NONE;

        // Evaluation is done at BAL_W+1 bits so amount plus charge cannot wrap.
        amt     = bidAmt[gnt_idx];
        amt_ext = {{(BAL_W + 1 - BID_W){1'b0}}, amt};
        chg_ext = {{(BAL_W + 1 - BID_W){1'b0}}, charge_q};
        bal_ext = {1'b0, bal_q[gnt_idx]};
        if (state_q != ACTIVE || !mask_q[gnt_idx]) bid_code = BID_MASKED;
        else if (amt <= max_q)                     bid_code = BID_LOW;
        else if (bal_ext < amt_ext + chg_ext)      bid_code = BID_FUNDS;
        else                                       bid_code = BID_OK;

        // A grant that collides with round end is dropped entirely.
        take_ok     = gnt_valid && !round_end;
        bid_win     = take_ok && (bid_code == BID_OK);
        gnt_oh      = take_ok ? (NUM_BIDDERS'(1) << gnt_idx) : '0;
        retract_hit = (state_q == ACTIVE) && !round_end && leader_valid_q && retract[leader_q];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ready_q        <= 1'b1;
            err_q          <= NONE;
            key_q          <= '0;
            mask_q         <= '0;
            reload_q       <= '1;
            timer_q        <= '0;
            charge_q       <= '0;
            max_q          <= '0;
            leader_valid_q <= 1'b0;
            leader_q       <= '0;
            bal_q          <= '0;
            ack_q          <= '0;
            win_q          <= '0;
            bid_err_q      <= '0;
            round_over_q   <= 1'b0;
        end else begin
            ready_q      <= !accept;
            round_over_q <= round_end;
            ack_q        <= gnt_oh;
            if (accept)    err_q    <= err_d;
            if (do_lock)   key_q    <= C_data;
            if (do_mask)   mask_q   <= C_data[NUM_BIDDERS-1:0];
            if (do_charge) charge_q <= C_data[BID_W-1:0];
            if (do_timer)  reload_q <= (C_data[TIMER_W-1:0] == '0) ? '1 : C_data[TIMER_W-1:0];

            if (do_start)                 timer_q <= reload_q;
            else if (state_q == ACTIVE)   timer_q <= timer_q - TIMER_W'(1);

            // Later assignments win: a same-cycle accepted bid overrides a retract.
            if (do_start) begin
                max_q          <= '0;
                leader_valid_q <= 1'b0;
            end else begin
                if (retract_hit) begin
                    max_q          <= '0;
                    leader_valid_q <= 1'b0;
                end
                if (bid_win) begin
                    max_q          <= amt;
                    leader_q       <= gnt_idx;
                    leader_valid_q <= 1'b1;
                end
            end

            if (do_start || do_unlock_ok)        win_q <= '0;
            else if (round_end && leader_valid_q) win_q <= win_q | (NUM_BIDDERS'(1) << leader_q);

            for (int i = 0; i < NUM_BIDDERS; i++) begin
                bid_err_q[i] <= gnt_oh[i] ? bid_code : BID_OK;
                if (do_load && C_idx == IDX_W'(i))
                    bal_q[i] <= C_data[BAL_W-1:0];
                else if (bid_win && gnt_idx == IDX_W'(i))
                    bal_q[i] <= bal_q[i] - BAL_W'(charge_q);
                else if (round_end && leader_valid_q && leader_q == IDX_W'(i))
                    bal_q[i] <= bal_q[i] - BAL_W'(max_q);
            end
        end
    end

    assign ack       = ack_q;
    assign win       = win_q;
    assign bidErr    = bid_err_q;
    assign balance   = bal_q;
    assign ready     = ready_q;
    assign err       = err_q;
    assign roundOver = round_over_q;
    assign maxBid    = max_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bidsn_ctrl.sv
// Directed bench for bidsn_ctrl; ack/bidErr order is checked through an expected queue.
module tb_bidsn_ctrl;
    import bidsn_pkg::*;

    localparam int N       = 3;
    localparam int BID_W   = 16;
    localparam int BAL_W   = 32;
    localparam int TIMER_W = 16;

    logic                       clk = 1'b0;
    logic                       reset_n = 1'b0;
    logic [3:0]                 C_op = 4'd0;
    logic                       C_start = 1'b0;
    logic [1:0]                 C_idx = 2'd0;
    logic [31:0]                C_data = 32'd0;
    logic [N-1:0]               bid = '0;
    logic [N-1:0]               retract = '0;
    logic [N-1:0][BID_W-1:0]    bidAmt = '0;
    logic [N-1:0]               ack, win;
    logic [N-1:0][1:0]          bidErr;
    logic [N-1:0][BAL_W-1:0]    balance;
    logic                       ready;
    logic [2:0]                 err;
    logic                       roundOver;
    logic [BID_W-1:0]           maxBid;
    state_t                     dbg_state;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    bidsn_ctrl #(.NUM_BIDDERS(N), .BID_W(BID_W), .BAL_W(BAL_W), .TIMER_W(TIMER_W)) dut (
        .clk(clk), .reset_n(reset_n), .C_op(C_op), .C_start(C_start), .C_idx(C_idx),
        .C_data(C_data), .bid(bid), .retract(retract), .bidAmt(bidAmt), .ack(ack),
        .win(win), .bidErr(bidErr), .balance(balance), .ready(ready), .err(err),
        .roundOver(roundOver), .maxBid(maxBid), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ent(input int idx, input logic [1:0] code);
        return {4'(idx), 2'b00, code};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bid     = '0;
        retract = '0;
        C_start = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    task automatic do_op(input logic [3:0] op, input logic [1:0] idx, input logic [31:0] data);
        int n = 0;
        while (!ready && n < 10) begin
            tick();
            n++;
        end
        if (!ready) check("ready_wait", ready, 1);
        C_op    = op;
        C_idx   = idx;
        C_data  = data;
        C_start = 1'b1;
        tick();
        C_start = 1'b0;
    endtask

    // Holds each bid until its ack, comparing every ack against the expected queue.
    task automatic run_bids(input logic [N-1:0] b);
        int n = 0;
        logic [7:0] e;
        bid = b;
        while (bid != '0 && n < 20) begin
            tick();
            n++;
            if (ack != '0) begin
                check("ack_onehot", $countones(ack), 1);
                for (int i = 0; i < N; i++) begin
                    if (ack[i]) begin
                        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hff;
                        check("ack_idx_code", ent(i, bidErr[i]), e);
                        bid[i] = 1'b0;
                    end
                end
            end
        end
        check("bids_acked", bid, '0);
        check("exp_q_drained", exp_q.size(), 0);
        bid = '0;
    endtask

    task automatic wait_round_over(input int max_cycles);
        int n = 0;
        while (!roundOver && n < max_cycles) begin
            tick();
            n++;
        end
        check("round_over_seen", roundOver, 1);
    endtask

    initial begin
        int ro_seen;

        do_reset();
        check("rst_ready", ready, 1);
        check("rst_err", err, NONE);
        check("rst_state", dbg_state, UNLOCKED);
        check("rst_maxbid", maxBid, 0);
        check("rst_balance", balance, '0);
        check("rst_win_ack", {win, ack, bidErr}, '0);
        check("rst_roundover", roundOver, 0);

        // Key handling and the one-cycle ready gap.
        do_op(Load_op, 2'd0, 32'd100);
        check("load_b0", balance[0], 100);
        check("ready_gap", ready, 0);
        C_op = Lock_op; C_data = 32'h77; C_start = 1'b1;
        tick();
        C_start = 1'b0;
        check("start_ignored", dbg_state, UNLOCKED);
        do_op(Lock_op, 2'd0, 32'h55);
        check("lock_state", dbg_state, LOCKED);
        do_op(Unlock_op, 2'd0, 32'h54);
        check("badkey_err", err, BADKEY);
        check("badkey_state", dbg_state, LOCKED);
        do_op(Unlock_op, 2'd0, 32'h55);
        check("unlock_err", err, NONE);
        check("unlock_state", dbg_state, UNLOCKED);

        // Round 1: single winning bid, timer expiry.
        do_op(Load_op, 2'd1, 32'd1000);
        do_op(Load_op, 2'd2, 32'd1000);
        do_op(SetMask_op, 2'd0, 32'h7);
        do_op(BidCharge_op, 2'd0, 32'd1);
        do_op(SetTimer_op, 2'd0, 32'd20);
        do_op(Lock_op, 2'd0, 32'h55);
        do_op(RoundActive_op, 2'd0, 32'd0);
        check("active_state", dbg_state, ACTIVE);
        bidAmt[1] = 16'd10;
        exp_q.push_back(ent(1, BID_OK));
        run_bids(3'b010);
        check("r1_maxbid", maxBid, 10);
        check("r1_bal1_charge", balance[1], 999);
        wait_round_over(30);
        check("r1_win", win, 3'b010);
        check("r1_bal1_final", balance[1], 989);
        check("r1_state", dbg_state, LOCKED);
        tick();
        check("r1_ro_pulse", roundOver, 0);
        check("r1_win_held", win, 3'b010);

        // Bid outside ACTIVE is acked as masked.
        bidAmt[0] = 16'd5;
        exp_q.push_back(ent(0, BID_MASKED));
        run_bids(3'b001);

        // Round 2: error codes, retract, RoundOver_op.
        do_op(Unlock_op, 2'd0, 32'h55);
        check("unlock_clears_win", win, 0);
        do_op(Load_op, 2'd0, 32'd5);
        do_op(SetMask_op, 2'd0, 32'h3);
        do_op(SetTimer_op, 2'd0, 32'd1000);
        do_op(Lock_op, 2'd0, 32'h55);
        do_op(RoundActive_op, 2'd0, 32'd0);
        check("r2_maxbid_clr", maxBid, 0);
        bidAmt[0] = 16'd9;
        exp_q.push_back(ent(0, BID_FUNDS));
        run_bids(3'b001);
        check("r2_funds_bal", balance[0], 5);
        bidAmt[1] = 16'd10;
        exp_q.push_back(ent(1, BID_OK));
        run_bids(3'b010);
        check("r2_maxbid10", maxBid, 10);
        check("r2_bal1", balance[1], 988);
        bidAmt[0] = 16'd10;
        exp_q.push_back(ent(0, BID_LOW));
        run_bids(3'b001);
        bidAmt[2] = 16'd50;
        exp_q.push_back(ent(2, BID_MASKED));
        run_bids(3'b100);
        check("r2_maxbid_kept", maxBid, 10);
        do_op(Load_op, 2'd0, 32'd777);
        check("r2_load_badop", err, BADOP);
        check("r2_load_noeffect", balance[0], 5);
        retract = 3'b001;
        tick();
        retract = '0;
        check("retract_nonleader", maxBid, 10);
        retract = 3'b010;
        tick();
        retract = '0;
        check("retract_leader", maxBid, 0);
        bidAmt[0] = 16'd1;
        exp_q.push_back(ent(0, BID_OK));
        run_bids(3'b001);
        check("r2_maxbid1", maxBid, 1);
        check("r2_bal0_charge", balance[0], 4);
        do_op(RoundOver_op, 2'd0, 32'd0);
        check("r2_roundover", roundOver, 1);
        check("r2_win", win, 3'b001);
        check("r2_bal0_final", balance[0], 3);
        check("r2_err", err, NONE);
        check("r2_state", dbg_state, LOCKED);

        // Round 3: simultaneous bids, arbitration order, reserved opcode, mid-round reset.
        do_reset();
        do_op(Load_op, 2'd0, 32'd1000);
        do_op(Load_op, 2'd1, 32'd1000);
        do_op(Load_op, 2'd2, 32'd1000);
        do_op(SetMask_op, 2'd0, 32'h7);
        do_op(BidCharge_op, 2'd0, 32'd1);
        do_op(SetTimer_op, 2'd0, 32'd30);
        do_op(Lock_op, 2'd0, 32'h55);
        do_op(RoundActive_op, 2'd0, 32'd0);
        bidAmt[0] = 16'd30; bidAmt[1] = 16'd40; bidAmt[2] = 16'd50;
        exp_q.push_back(ent(0, BID_OK));
        exp_q.push_back(ent(1, BID_OK));
        exp_q.push_back(ent(2, BID_OK));
        run_bids(3'b111);
        check("r3_maxbid50", maxBid, 50);
        bidAmt[1] = 16'd55;
        exp_q.push_back(ent(1, BID_OK));
        run_bids(3'b010);
        bidAmt[0] = 16'd60; bidAmt[1] = 16'd70; bidAmt[2] = 16'd80;
`ifdef BIDSN_RR_ARB_EN
        exp_q.push_back(ent(2, BID_OK));
        exp_q.push_back(ent(0, BID_LOW));
        exp_q.push_back(ent(1, BID_LOW));
`else
        exp_q.push_back(ent(0, BID_OK));
        exp_q.push_back(ent(1, BID_OK));
        exp_q.push_back(ent(2, BID_OK));
`endif
        run_bids(3'b111);
        check("r3_maxbid80", maxBid, 80);
        check("r3_bal2", balance[2], 998);
        do_op(4'd4, 2'd0, 32'd0);
        check("reserved_badop", err, BADOP);
        check("reserved_state", dbg_state, ACTIVE);

        reset_n = 1'b0;
        tick();
        check("midrst_outputs", {ack, win, bidErr, maxBid, err, roundOver}, '0);
        check("midrst_balance", balance, '0);
        check("midrst_state", dbg_state, UNLOCKED);
        check("midrst_ready", ready, 1);
        tick();
        reset_n = 1'b1;
        ro_seen = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (roundOver || win != '0) ro_seen = 1;
        end
        check("midrst_no_roundover", ro_seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
